// File: rtl/pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : pll_drp_reconfig
// Purpose  : Queues masked DRP register writes and applies them to a PLL as
//            read-modify-write pairs. The PLL is held in reset while it is
//            reprogrammed, then released, and the sequence waits for re-lock.
// Ports    : refclk, rst           - clock, asynchronous active-high reset
//            cfg_valid/cfg_ready   - write-entry handshake
//            cfg_addr/data/mask    - DRP address, new value, keep-mask (1=keep)
//            commit                - one-cycle request to apply queued entries
//            busy, done, error,    - sequence status; err_code 1 = DRDY
//            err_code                timeout, 2 = lock timeout
//            pll_locked_in, locked - raw and synchronised PLL lock
//            pll_rst               - PLL reset output
//            drp_*                 - DRP master port
// Revision : 1.0 - initial release
// ============================================================================
module pll_drp_reconfig #(
  parameter int DEPTH        = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 4
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic [15:0] cfg_mask,
  input  logic        commit,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  input  logic        pll_locked_in,
  output logic        locked,
  output logic        pll_rst,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAX_A = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int MAX_T = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
  localparam int CW    = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [1:0]    ERR_DRDY  = 2'd1;
  localparam logic [1:0]    ERR_LOCK  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HOLD      = 4'd1,
    ST_RD_REQ    = 4'd2,
    ST_RD_WAIT   = 4'd3,
    ST_WR_REQ    = 4'd4,
    ST_WR_WAIT   = 4'd5,
    ST_RELEASE   = 4'd6,
    ST_WAIT_LOCK = 4'd7,
    ST_FINISH    = 4'd8
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           pll_rst_nxt;
  logic           pop, flush, err_drdy, err_lock, err_clr;
  logic           ready_en;
  logic           lock_meta;
  logic [15:0]    old_val;
  logic [15:0]    wr_value;

  // ------------------------------------------------------------------------
  // Write queue. The extra pointer bit distinguishes full from empty.
  // ------------------------------------------------------------------------
  logic [6:0]  q_addr [DEPTH];
  logic [15:0] q_data [DEPTH];
  logic [15:0] q_mask [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW-1:0] head;
  logic        q_empty, q_full, q_last, push;

  assign head    = rd_ptr[AW-1:0];
  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign q_last  = ((rd_ptr + PTR_ONE) == wr_ptr);

  assign busy      = (state != ST_IDLE) && (state != ST_FINISH);
  assign done      = (state == ST_FINISH);
  // ready_en keeps cfg_ready low until the first edge after reset release
  assign cfg_ready = ready_en && !q_full && !busy;
  assign push      = cfg_valid && cfg_ready;

  always_ff @(posedge refclk) begin
    if (push) begin
      q_addr[wr_ptr[AW-1:0]] <= cfg_addr;
      q_data[wr_ptr[AW-1:0]] <= cfg_data;
      q_mask[wr_ptr[AW-1:0]] <= cfg_mask;
    end
  end

  // push only happens while idle and flush/pop only while busy, so they
  // never collide on the same edge
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ------------------------------------------------------------------------
  // Lock synchroniser
  // ------------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked    <= 1'b0;
    end else begin
      lock_meta <= pll_locked_in;
      locked    <= lock_meta;
    end
  end

  // ------------------------------------------------------------------------
  // Sequencer state register and status flags
  // ------------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pll_rst  <= 1'b1;
      error    <= 1'b0;
      err_code <= 2'd0;
      old_val  <= 16'd0;
    end else begin
      state   <= state_nxt;
      // one shared counter times HOLD, DRDY waits and lock wait; it restarts
      // on every state change
      cnt     <= ((state_nxt != state) || (state == ST_IDLE)) ? '0 : cnt + CNT_ONE;
      pll_rst <= pll_rst_nxt;
      if (err_clr) begin
        error    <= 1'b0;
        err_code <= 2'd0;
      end else if (err_drdy) begin
        error    <= 1'b1;
        err_code <= ERR_DRDY;
      end else if (err_lock) begin
        error    <= 1'b1;
        err_code <= ERR_LOCK;
      end
      if ((state == ST_RD_WAIT) && drp_drdy) old_val <= drp_do;
    end
  end

  always_comb begin
    state_nxt   = state;
    pll_rst_nxt = pll_rst;
    pop         = 1'b0;
    flush       = 1'b0;
    err_drdy    = 1'b0;
    err_lock    = 1'b0;
    err_clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        pll_rst_nxt = 1'b0;
        if (commit) begin
          err_clr = 1'b1;
          if (q_empty) begin
            state_nxt = ST_FINISH;
          end else begin
            state_nxt   = ST_HOLD;
            pll_rst_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) state_nxt = ST_RD_REQ;
      end
      ST_RD_REQ: state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (drp_drdy) begin
          state_nxt = ST_WR_REQ;
        end else if (cnt == DRDY_LAST) begin
          err_drdy  = 1'b1;
          flush     = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_WR_REQ: state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (drp_drdy) begin
          pop       = 1'b1;
          state_nxt = q_last ? ST_RELEASE : ST_RD_REQ;
        end else if (cnt == DRDY_LAST) begin
          err_drdy  = 1'b1;
          flush     = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        pll_rst_nxt = 1'b0;
        // an aborted DRP sequence finishes without waiting for lock
        state_nxt   = error ? ST_FINISH : ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked) begin
          state_nxt = ST_FINISH;
        end else if (cnt == LOCK_LAST) begin
          err_lock  = 1'b1;
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // DRP port: strobes come from single-cycle request states, so drp_den can
  // never be high on two consecutive cycles
  // ------------------------------------------------------------------------
  assign wr_value  = (old_val & q_mask[head]) | (q_data[head] & ~q_mask[head]);
  assign drp_den   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign drp_dwe   = (state == ST_WR_REQ);
  assign drp_daddr = drp_den ? q_addr[head] : 7'd0;
  assign drp_di    = drp_dwe ? wr_value : 16'd0;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_drp_reconfig
// Purpose  : Self-checking bench for pll_drp_reconfig. A DRP register model
//            answers reads/writes; expected writes are queued when entries
//            are pushed and checked when the DUT issues them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_drp_reconfig;

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;
  logic        cfg_valid, cfg_ready, commit, busy, done, error;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data, cfg_mask;
  logic [1:0]  err_code;
  logic        pll_locked_in, locked, pll_rst;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do;

  always #5 refclk = ~refclk;

  pll_drp_reconfig dut (
    .refclk(refclk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .commit(commit), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .pll_locked_in(pll_locked_in), .locked(locked), .pll_rst(pll_rst),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy)
  );

  typedef struct packed {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         sb[$];
  logic [15:0] mem    [128];
  logic [15:0] shadow [128];
  int          rsp_lat = 3;
  int          withhold_idx = 0;
  int          rd_count = 0;
  bit          lock_stuck = 1'b0;

  // results of run_commit
  int          w_cyc, w_fall_cyc, w_rst_hi;
  bit          w_den, w_rst_ever, w_timeout, w_ready_busy, w_locked_done, w_err, w_rst_at_done;
  logic [1:0]  w_code;

  // ---------------- DRP register model / responder ----------------
  initial begin : drp_responder
    int          cnt;
    logic [15:0] val;
    logic        prev_den;
    wr_t         e;
    cnt = 0; val = '0; prev_den = 1'b0;
    drp_drdy = 1'b0; drp_do = '0;
    forever begin
      @(negedge refclk);
      drp_drdy = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drp_drdy = 1'b1;
          drp_do   = val;
        end
      end
      if (drp_den === 1'b1) begin
        vectors++;
        if (prev_den) begin
          miscompares++;
          $display("FAIL den_strobe: drp_den high two cycles in a row, required single-cycle strobe");
        end
        if (drp_dwe === 1'b1) begin
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL drp_write: unexpected write addr=%h di=%h, required no write", drp_daddr, drp_di);
          end else begin
            e = sb.pop_front();
            if (drp_daddr !== e.a || drp_di !== e.d) begin
              miscompares++;
              $display("FAIL drp_write: got addr=%h di=%h, expected addr=%h di=%h", drp_daddr, drp_di, e.a, e.d);
            end
          end
          mem[drp_daddr] = drp_di;
          val = 16'd0;
        end else begin
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL drp_read: unexpected read addr=%h, required no read", drp_daddr);
          end else if (drp_daddr !== sb[0].a) begin
            miscompares++;
            $display("FAIL drp_read: got addr=%h, expected addr=%h", drp_daddr, sb[0].a);
          end
          val = mem[drp_daddr];
          rd_count++;
        end
        if (!(drp_dwe === 1'b0 && withhold_idx != 0 && rd_count == withhold_idx)) cnt = rsp_lat;
      end
      prev_den = (drp_den === 1'b1);
    end
  end

  // ---------------- PLL lock model ----------------
  initial begin : lock_model
    int n;
    n = 0;
    pll_locked_in = 1'b0;
    forever begin
      @(negedge refclk);
      if (pll_rst !== 1'b0 || lock_stuck) begin
        pll_locked_in = 1'b0;
        n = 0;
      end else if (n < 5) begin
        n++;
      end else begin
        pll_locked_in = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic push_entry(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m, output bit acc);
    wr_t e;
    @(negedge refclk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_mask = m;
    acc = (cfg_ready === 1'b1);
    @(posedge refclk);
    #1;
    cfg_valid = 1'b0;
    if (acc) begin
      e.a = a;
      e.d = (shadow[a] & m) | (d & ~m);
      shadow[a] = e.d;
      sb.push_back(e);
    end
  endtask

  task automatic run_commit(input int budget, input int extra_at);
    w_cyc = 0; w_fall_cyc = -1; w_rst_hi = 0;
    w_den = 0; w_rst_ever = 0; w_timeout = 1; w_ready_busy = 0;
    w_locked_done = 0; w_err = 0; w_rst_at_done = 0; w_code = 2'd0;
    @(negedge refclk);
    commit = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge refclk);
      commit = (i == extra_at);
      if (pll_rst === 1'b1) begin
        w_rst_ever = 1;
        if (!w_den) w_rst_hi++;
      end else if (w_rst_ever && w_fall_cyc < 0) begin
        w_fall_cyc = i;
      end
      if (drp_den === 1'b1) w_den = 1;
      if (busy === 1'b1 && cfg_ready !== 1'b0) w_ready_busy = 1;
      if (done === 1'b1) begin
        w_cyc = i; w_timeout = 0;
        w_locked_done = (locked === 1'b1);
        w_err = (error === 1'b1);
        w_code = err_code;
        w_rst_at_done = (pll_rst === 1'b1);
        break;
      end
    end
    commit = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    vectors++;
    if ({cfg_ready, busy, done, error, err_code} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_status: got ready/busy/done/err/code=%b, expected 000000", {cfg_ready, busy, done, error, err_code});
    end
    vectors++;
    if ({drp_den, drp_dwe, drp_daddr, drp_di} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_drp: got den=%b dwe=%b addr=%h di=%h, expected all zero", drp_den, drp_dwe, drp_daddr, drp_di);
    end
    vectors++;
    if ({locked, pll_rst} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_pll: got locked=%b pll_rst=%b, expected locked=0 pll_rst=1", locked, pll_rst);
    end
    @(negedge refclk);
    rst = 1'b0;
    #1;
    vectors++;
    if (pll_rst !== 1'b1 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_pre_edge: got pll_rst=%b ready=%b, expected 1 0", pll_rst, cfg_ready);
    end
    @(posedge refclk);
    #1;
    vectors++;
    if (pll_rst !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_edge: got pll_rst=%b ready=%b, expected 0 1", pll_rst, cfg_ready);
    end
  endtask

  task automatic test_basic();
    bit a0, a1;
    push_entry(7'h08, 16'h1041, 16'h1000, a0);
    push_entry(7'h14, 16'h0820, 16'h0000, a1);
    vectors++;
    if (!(a0 && a1)) begin
      miscompares++;
      $display("FAIL basic_accept: got accepted=%b%b, expected 11", a0, a1);
    end
    rsp_lat = 3;
    run_commit(3000, 0);
    vectors++;
    if (w_timeout) begin
      miscompares++;
      $display("FAIL basic_done_timeout: done not seen within 3000 cycles, expected done pulse");
    end
    vectors++;
    if (w_rst_hi < 4) begin
      miscompares++;
      $display("FAIL basic_rst_hold: got %0d pll_rst cycles before first den, expected >= 4", w_rst_hi);
    end
    vectors++;
    if (!w_locked_done || w_err || w_code !== 2'd0) begin
      miscompares++;
      $display("FAIL basic_status: got locked=%b error=%b code=%0d at done, expected 1 0 0", w_locked_done, w_err, w_code);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL basic_writes: got %0d writes missing, expected 0", sb.size());
    end
    @(negedge refclk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b one cycle later, expected 0 0", done, busy);
    end
  endtask

  task automatic test_empty();
    run_commit(20, 0);
    vectors++;
    if (w_timeout || w_cyc != 1) begin
      miscompares++;
      $display("FAIL empty_latency: got done after %0d cycles (timeout=%b), expected 1", w_cyc, w_timeout);
    end
    vectors++;
    if (w_rst_ever || w_den) begin
      miscompares++;
      $display("FAIL empty_no_activity: got pll_rst_seen=%b den_seen=%b, expected 0 0", w_rst_ever, w_den);
    end
  endtask

  task automatic test_fill();
    bit acc;
    int n_acc;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      push_entry(7'($urandom), 16'($urandom), 16'($urandom), acc);
      if (acc) n_acc++;
    end
    vectors++;
    if (n_acc != 8) begin
      miscompares++;
      $display("FAIL fill_accept: got %0d accepted, expected 8", n_acc);
    end
    push_entry(7'h33, 16'hBEEF, 16'h00FF, acc);
    vectors++;
    if (acc || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: got 9th accepted=%b ready=%b, expected 0 0", acc, cfg_ready);
    end
    rsp_lat = 2;
    run_commit(5000, 10);
    vectors++;
    if (w_timeout || sb.size() != 0) begin
      miscompares++;
      $display("FAIL fill_sequence: got timeout=%b writes_missing=%0d, expected 0 0", w_timeout, sb.size());
    end
    vectors++;
    if (w_ready_busy) begin
      miscompares++;
      $display("FAIL fill_ready_busy: got cfg_ready=1 while busy, expected 0");
    end
    @(negedge refclk);
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_ready_after: got cfg_ready=%b after done, expected 1", cfg_ready);
    end
    acc = 0;
    repeat (10) begin
      @(negedge refclk);
      if (busy === 1'b1 || done === 1'b1) acc = 1;
    end
    vectors++;
    if (acc) begin
      miscompares++;
      $display("FAIL fill_commit_ignored: got second sequence after busy commit, expected none");
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    rsp_lat = 1;
    push_entry(7'h21, 16'h1234, 16'hF00F, acc);
    push_entry(7'h22, 16'h5678, 16'h0FF0, acc);
    run_commit(3000, 0);
    push_entry(7'h21, 16'hAAAA, 16'h5555, acc);
    run_commit(3000, 0);
    vectors++;
    if (w_timeout || w_err || sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_sequence: got timeout=%b error=%b writes_missing=%0d, expected 0 0 0", w_timeout, w_err, sb.size());
    end
  endtask

  task automatic test_drdy_timeout();
    bit acc;
    push_entry(7'h40, 16'h0001, 16'hFF00, acc);
    push_entry(7'h41, 16'h0002, 16'hFF00, acc);
    push_entry(7'h42, 16'h0003, 16'hFF00, acc);
    rd_count = 0;
    withhold_idx = 2;
    rsp_lat = 3;
    run_commit(3000, 0);
    withhold_idx = 0;
    vectors++;
    if (w_timeout || !w_err || w_code !== 2'd1 || w_rst_at_done) begin
      miscompares++;
      $display("FAIL drdy_err: got timeout=%b error=%b code=%0d pll_rst=%b, expected 0 1 1 0", w_timeout, w_err, w_code, w_rst_at_done);
    end
    vectors++;
    if (sb.size() != 2) begin
      miscompares++;
      $display("FAIL drdy_partial: got %0d unwritten entries, expected 2", sb.size());
    end
    sb.delete();
    shadow = mem;
    @(negedge refclk);
    vectors++;
    if (error !== 1'b1 || err_code !== 2'd1) begin
      miscompares++;
      $display("FAIL drdy_sticky: got error=%b code=%0d, expected 1 1", error, err_code);
    end
    run_commit(20, 0);
    vectors++;
    if (w_timeout || w_cyc != 1 || w_rst_ever || w_err || w_code !== 2'd0) begin
      miscompares++;
      $display("FAIL drdy_flushed: got cycles=%0d pll_rst_seen=%b error=%b code=%0d, expected 1 0 0 0", w_cyc, w_rst_ever, w_err, w_code);
    end
  endtask

  task automatic test_rst_mid();
    bit acc, found;
    push_entry(7'h50, 16'h1111, 16'h0000, acc);
    push_entry(7'h51, 16'h2222, 16'h0000, acc);
    rsp_lat = 10;
    @(negedge refclk);
    commit = 1'b1;
    @(negedge refclk);
    commit = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (drp_den === 1'b1 && drp_dwe === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge refclk);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rstmid_reach: got no write within 200 cycles, expected write");
    end
    @(negedge refclk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({cfg_ready, busy, done, error, err_code, drp_den, drp_dwe, drp_daddr, drp_di, locked} !== 32'd0 || pll_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_async: got ready=%b busy=%b done=%b den=%b pll_rst=%b locked=%b, expected 0 0 0 0 1 0", cfg_ready, busy, done, drp_den, pll_rst, locked);
    end
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    #1;
    vectors++;
    if (pll_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_hold: got pll_rst=%b before first edge, expected 1", pll_rst);
    end
    @(posedge refclk);
    #1;
    vectors++;
    if (pll_rst !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_release: got pll_rst=%b ready=%b, expected 0 1", pll_rst, cfg_ready);
    end
    repeat (20) @(negedge refclk);
    sb.delete();
    shadow = mem;
    run_commit(20, 0);
    vectors++;
    if (w_timeout || w_cyc != 1 || w_rst_ever || w_den) begin
      miscompares++;
      $display("FAIL rstmid_queue_empty: got cycles=%0d pll_rst_seen=%b den_seen=%b, expected 1 0 0", w_cyc, w_rst_ever, w_den);
    end
  endtask

  task automatic test_lock_timeout();
    bit acc;
    int gap;
    push_entry(7'h60, 16'hC3C3, 16'h0F0F, acc);
    rsp_lat = 2;
    lock_stuck = 1'b1;
    run_commit(70000, 0);
    gap = w_cyc - w_fall_cyc;
    vectors++;
    if (w_timeout || !w_err || w_code !== 2'd2) begin
      miscompares++;
      $display("FAIL lock_err: got timeout=%b error=%b code=%0d, expected 0 1 2", w_timeout, w_err, w_code);
    end
    vectors++;
    if (w_fall_cyc < 0 || gap < 65535 || gap > 65537) begin
      miscompares++;
      $display("FAIL lock_wait_len: got %0d cycles from pll_rst release to done, expected 65535..65537", gap);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL lock_writes: got %0d writes missing, expected 0", sb.size());
    end
    @(negedge refclk);
    vectors++;
    if (error !== 1'b1 || err_code !== 2'd2) begin
      miscompares++;
      $display("FAIL lock_sticky: got error=%b code=%0d, expected 1 2", error, err_code);
    end
    lock_stuck = 1'b0;
    repeat (20) @(negedge refclk);
    vectors++;
    if (locked !== 1'b1 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_idle_relock: got locked=%b error=%b, expected 1 1", locked, error);
    end
    run_commit(20, 0);
    vectors++;
    if (w_timeout || w_err || w_code !== 2'd0) begin
      miscompares++;
      $display("FAIL lock_err_clear: got timeout=%b error=%b code=%0d, expected 0 0 0", w_timeout, w_err, w_code);
    end
  endtask

  initial begin : main
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_mask = '0; commit = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = (i == 8 || i == 20) ? 16'hF0F0 : 16'(i * 515);
    end
    shadow = mem;
    test_reset();
    test_basic();
    test_empty();
    test_fill();
    test_back_to_back();
    test_drdy_timeout();
    test_rst_mid();
    test_lock_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
